axis_echo: RTL and testbench
============================

// Module: axis_echo
// PURPOSE
//  Stereo AXI-Stream feedback-echo stage between the volume controller output and the I2S2 TX input.
//  It adds a delayed, attenuated copy of each channel's own past output to the live sample, in axis_clk.
//  A switch-selected delay is read from an on-chip circular buffer; echo_en=0 passes audio through unchanged.
// PARAMETERS
//  DATA_WIDTH   24  signed sample width (two's complement)
//  ADDR_WIDTH   12  log2 of delay-buffer depth in stereo frames (4096 frames)
//  SEL_WIDTH    4   width of delay_sel; one delay step = 2^(ADDR_WIDTH-SEL_WIDTH) frames
//  DECAY_SHIFT  1   feedback gain = 2^-DECAY_SHIFT (arithmetic right shift)
// PORTS
//  axis_clk      in   1           sole clock
//  axis_resetn   in   1           reset, asynchronous, active-low
//  echo_en       in   1           1 = mix echo, 0 = bypass
//  delay_sel     in   SEL_WIDTH   delay in steps; 0 = bypass
//  s_axis_data   in   DATA_WIDTH  input sample
//  s_axis_valid  in   1           input valid
//  s_axis_ready  out  1           input ready
//  s_axis_last   in   1           0 = left, 1 = right (frame end)
//  m_axis_data   out  DATA_WIDTH  output sample
//  m_axis_valid  out  1           output valid
//  m_axis_ready  in   1           output ready
//  m_axis_last   out  1           copy of accepted s_axis_last
// BEHAVIOUR
//  Reset: state=CLEAR, s_axis_ready=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, wr_ptr=0, clr_addr=0.
//  Buffer: one RAM of 2^(ADDR_WIDTH+1) words, address {chan, frame_ptr}; sync read, 1-cycle latency.
//  FSM:
//   CLEAR: write 0 to clr_addr each cycle, increment; after the last address -> IDLE.
//          Lasts exactly 2^(ADDR_WIDTH+1) cycles; s_axis_ready=0 throughout.
//   IDLE : s_axis_ready=1. On valid&ready capture data, chan=s_axis_last, and delay_sel;
//          issue read at {chan, (wr_ptr - D) mod 2^ADDR_WIDTH}, D = delay_sel<<(ADDR_WIDTH-SEL_WIDTH); -> READ.
//   READ : RAM data returns; -> MIX.
//   MIX  : mix = (echo_en && D!=0) ? sat(in + (rd >>> DECAY_SHIFT)) : in;
//          write mix to {chan, wr_ptr}; register m_axis_data=mix, m_axis_last=chan, m_axis_valid=1; -> OUT.
//   OUT  : hold data/last/valid stable until m_axis_ready. On handshake: m_axis_valid=0;
//          if chan=1, wr_ptr++ (wraps at 2^ADDR_WIDTH); -> IDLE.
//  Latency: accept -> m_axis_valid = 3 cycles. One sample in flight; s_axis_ready=0 outside IDLE.
//  Arithmetic: sum in DATA_WIDTH+1 bits; clamp to +2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1).
//   Shift is arithmetic (sign-preserving).
//  Bypass (echo_en=0 or D=0): output = input exactly; the input is still written to the buffer,
//   so a later enable echoes recent audio.
//  delay_sel and echo_en are sampled at accept; changes apply from the next accepted sample.
//  Channel pairing relies on s_axis_last only; two consecutive lefts both use the same wr_ptr (no error flag).
//  Max delay ((2^SEL_WIDTH-1) steps) is always < 2^ADDR_WIDTH, so the read never aliases the write slot.
//  Reset asserted mid-operation: all outputs return to reset values immediately;
//   the in-flight sample is dropped; CLEAR reruns.
// TESTING  (bench uses ADDR_WIDTH=4, SEL_WIDTH=2, DECAY_SHIFT=1 -> step = 4 frames)
//  1 Release reset -> s_axis_ready=0 for exactly 32 cycles, then 1; RAM all zero.
//  2 echo_en=1, delay_sel=1, left 0x400000 then zero frames (right always 0)
//    -> left out f0=0x400000, f4=0x200000, f8=0x100000, all else 0.
//  3 echo_en=0, random samples -> m_axis_data==s_axis_data, m_axis_last==s_axis_last,
//    valid 3 cycles after accept.
//  4 delay_sel=1, steady left 0x7FFFF0 -> from f4 on, output clamps to 0x7FFFFF;
//    negative mirror clamps to 0x800000.
//  5 m_axis_ready=0 for 10 cycles during OUT -> data/last/valid held, s_axis_ready=0;
//    release -> one transfer, back to IDLE.
//  6 Assert reset in READ -> m_axis_valid=0 at once; after release CLEAR rerun (32 cycles),
//    stale echo absent.

Source files
------------

// File: rtl/axis_echo.sv
// -----------------------------------------------------------------------------
// axis_echo
//   Stereo AXI-Stream feedback-echo stage. Each accepted sample is mixed with an
//   attenuated copy of the same channel's own output from D frames earlier,
//   where D = delay_sel * 2^(ADDR_WIDTH-SEL_WIDTH). The mixed result is written
//   back into a circular buffer, so the echo keeps decaying by 2^-DECAY_SHIFT
//   on each repeat. With echo_en=0 or delay_sel=0 the sample passes unchanged,
//   but it is still written to the buffer.
//
// Ports
//   axis_clk, axis_resetn       clock, asynchronous active-low reset
//   echo_en                     1 = mix echo, 0 = bypass (sampled at accept)
//   delay_sel[SEL_WIDTH]        delay in steps, 0 = bypass (sampled at accept)
//   s_axis_data/valid/ready/last  input stream; last=0 left, last=1 right
//   m_axis_data/valid/ready/last  output stream; last is the accepted channel
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. The source holds data/last stable while valid is high and ready is
//   low; valid never waits on ready. Only one sample is in flight, so
//   s_axis_ready is high only in IDLE.
// -----------------------------------------------------------------------------
module axis_echo #(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 12,
    parameter int SEL_WIDTH   = 4,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic                  echo_en,
    input  logic [SEL_WIDTH-1:0]  delay_sel,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last
);

    localparam int DEPTH      = 2 ** (ADDR_WIDTH + 1);
    localparam int STEP_SHIFT = ADDR_WIDTH - SEL_WIDTH;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        MIX   = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH:0]     clr_addr;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    chan;
    logic                    echo_on;
    logic [DATA_WIDTH-1:0]   rd_data;

    // Delay buffer: address is {channel, frame pointer}.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   delay;
    logic [ADDR_WIDTH:0]     rd_addr;
    logic                    ram_we;
    logic [ADDR_WIDTH:0]     ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    logic signed [DATA_WIDTH-1:0] echo_part;
    logic signed [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0]        sat_sum;
    logic [DATA_WIDTH-1:0]        mix;

    assign accept = (state == IDLE) && s_axis_valid && s_axis_ready;

    // delay_sel scaled to frames; subtraction wraps modulo the buffer depth.
    assign delay   = {delay_sel, {STEP_SHIFT{1'b0}}};
    assign rd_addr = {s_axis_last, wr_ptr - delay};

    // CLEAR owns the write port until IDLE; afterwards only MIX writes.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {chan, wr_ptr};
        ram_wdata = mix;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else if (state == MIX) begin
            ram_we    = 1'b1;
        end
    end

    // Synchronous RAM; the read is launched on the accept edge so the data is
    // ready by the time READ hands over to MIX.
    always_ff @(posedge axis_clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (accept) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Sum in one extra bit; overflow shows up as the top two bits disagreeing.
    always_comb begin
        echo_part = $signed(rd_data) >>> DECAY_SHIFT;
        sum       = $signed({in_data[DATA_WIDTH-1], in_data}) +
                    $signed({echo_part[DATA_WIDTH-1], echo_part});
        sat_sum   = sum[DATA_WIDTH-1:0];
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            sat_sum = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        mix = echo_on ? sat_sum : in_data;
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state        <= CLEAR;
            clr_addr     <= '0;
            wr_ptr       <= '0;
            in_data      <= '0;
            chan         <= 1'b0;
            echo_on      <= 1'b0;
            s_axis_ready <= 1'b0;
            m_axis_data  <= '0;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                        state        <= IDLE;
                        s_axis_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (s_axis_valid) begin
                        in_data      <= s_axis_data;
                        chan         <= s_axis_last;
                        echo_on      <= echo_en && (delay_sel != '0);
                        s_axis_ready <= 1'b0;
                        state        <= READ;
                    end
                end
                READ: begin
                    state <= MIX;
                end
                MIX: begin
                    m_axis_data  <= mix;
                    m_axis_last  <= chan;
                    m_axis_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (m_axis_ready) begin
                        m_axis_valid <= 1'b0;
                        // A frame ends on the right channel.
                        if (chan) begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        s_axis_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_echo.sv
// -----------------------------------------------------------------------------
// tb_axis_echo
//   Bench for axis_echo with ADDR_WIDTH=4, SEL_WIDTH=2, DECAY_SHIFT=1
//   (16-frame buffer per channel, one delay step = 4 frames, echo gain 1/2).
// -----------------------------------------------------------------------------
module tb_axis_echo;

    localparam int DW = 24;

    logic          clk;
    logic          rst_n;
    logic          echo_en;
    logic [1:0]    delay_sel;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    int errors;
    int checks;

    // Expected outputs: {last, data}
    logic [DW:0]   exp_q[$];

    // Reference model: per-channel history of outputs, 16 frames deep.
    logic [DW-1:0] mdl_mem [2][16];
    int            mdl_wp;

    axis_echo #(
        .DATA_WIDTH (24),
        .ADDR_WIDTH (4),
        .SEL_WIDTH  (2),
        .DECAY_SHIFT(1)
    ) dut (
        .axis_clk    (clk),
        .axis_resetn (rst_n),
        .echo_en     (echo_en),
        .delay_sel   (delay_sel),
        .s_axis_data (s_data),
        .s_axis_valid(s_valid),
        .s_axis_ready(s_ready),
        .s_axis_last (s_last),
        .m_axis_data (m_data),
        .m_axis_valid(m_valid),
        .m_axis_ready(m_ready),
        .m_axis_last (m_last)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                mdl_mem[c][i] = '0;
            end
        end
        mdl_wp = 0;
    endtask

    task automatic model_step(input logic [DW-1:0] d, input logic l, input logic en,
                              input logic [1:0] sel, output logic [DW-1:0] e);
        int dly;
        int idx;
        int s;
        int half;
        dly = int'(sel) * 4;
        idx = (mdl_wp - dly + 16) % 16;
        if (en && dly != 0) begin
            half = int'($signed(mdl_mem[l][idx])) >>> 1;
            s    = int'($signed(d)) + half;
            if (s > 8388607)       e = 24'h7FFFFF;
            else if (s < -8388608) e = 24'h800000;
            else                   e = 24'(s);
        end else begin
            e = d;
        end
        mdl_mem[l][mdl_wp] = e;
        if (l) mdl_wp = (mdl_wp + 1) % 16;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [DW-1:0] d, input logic l, input logic en,
                        input logic [1:0] sel, input bit use_hard, input logic [DW-1:0] hard_exp);
        int n;
        logic [DW-1:0] e;
        n = 0;
        s_data    = d;
        s_last    = l;
        echo_en   = en;
        delay_sel = sel;
        s_valid   = 1'b1;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: s_axis_ready=%b required 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        model_step(d, l, en, sel, e);
        exp_q.push_back({l, use_hard ? hard_exp : e});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Waits for the output, compares against the scoreboard, completes the handshake.
    task automatic recv();
        int n;
        logic [DW:0] exp;
        n = 0;
        while (m_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL output_timeout: m_axis_valid=%b required 1", m_valid);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (m_data !== exp[DW-1:0]) begin
            errors++;
            $display("FAIL out_data: got %h required %h", m_data, exp[DW-1:0]);
        end
        checks++;
        if (m_last !== exp[DW]) begin
            errors++;
            $display("FAIL out_last: got %b required %b", m_last, exp[DW]);
        end
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: m_axis_valid=%b s_axis_ready=%b required 0/1", m_valid, s_ready);
        end
    endtask

    // Called at the negedge of reset release; counts cycles until s_axis_ready.
    task automatic wait_clear(input string name);
        int cnt;
        cnt = 0;
        while (s_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 32) begin
            errors++;
            $display("FAIL %s_clear_len: ready after %0d cycles required 32", name, cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%h last=%b required 0/0/0/0",
                     s_ready, m_valid, m_data, m_last);
        end
        rst_n = 1'b1;
        wait_clear("reset");
    endtask

    task automatic test_echo_decay();
        logic [DW-1:0] e;
        for (int f = 0; f < 12; f++) begin
            e = (f == 0) ? 24'h400000 : (f == 4) ? 24'h200000 : (f == 8) ? 24'h100000 : 24'h000000;
            send((f == 0) ? 24'h400000 : 24'h0, 1'b0, 1'b1, 2'd1, 1'b1, e);
            recv();
            send(24'h0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h0);
            recv();
        end
    endtask

    task automatic test_bypass_random();
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    sel;
        for (int i = 0; i < 16; i++) begin
            d   = DW'($urandom_range(0, 24'hFFFFFF));
            l   = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            send(d, l, 1'b0, sel, 1'b1, d);
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early: m_axis_valid=%b required 0", m_valid);
            end
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_2: m_axis_valid=%b required 0", m_valid);
            end
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1) begin
                errors++;
                $display("FAIL latency_3: m_axis_valid=%b required 1", m_valid);
            end
            recv();
        end
    endtask

    task automatic test_sel_zero();
        logic [DW-1:0] d;
        for (int i = 0; i < 8; i++) begin
            d = DW'($urandom_range(0, 24'hFFFFFF));
            send(d, 1'(i % 2), 1'b1, 2'd0, 1'b1, d);
            recv();
        end
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 20; f++) begin
            send(24'h7FFFF0, 1'b0, 1'b1, 2'd1, (f >= 4), 24'h7FFFFF);
            recv();
            send(24'h800010, 1'b1, 1'b1, 2'd1, (f >= 4), 24'h800000);
            recv();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        logic [DW:0]   exp;
        d = DW'($urandom_range(0, 24'hFFFFFF));
        m_ready = 1'b0;
        send(d, 1'b0, 1'b0, 2'd0, 1'b1, d);
        exp = exp_q[0];
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp[DW-1:0] || m_last !== exp[DW] || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b data=%h last=%b s_ready=%b required 1/%h/%b/0",
                         i, m_valid, m_data, m_last, s_ready, exp[DW-1:0], exp[DW]);
            end
            @(negedge clk);
        end
        recv();
        // Close the frame so the pairing stays regular.
        send(d, 1'b1, 1'b0, 2'd0, 1'b1, d);
        recv();
    endtask

    task automatic test_reset_mid();
        send(24'h123456, 1'b0, 1'b1, 2'd1, 1'b0, 24'h0);
        // DUT is now in READ.
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b ready=%b data=%h last=%b required 0/0/0/0",
                     m_valid, s_ready, m_data, m_last);
        end
        void'(exp_q.pop_back());
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("midreset");
        // Old buffer contents would show up here as echo if CLEAR had not run.
        for (int f = 0; f < 4; f++) begin
            send(24'h000100, 1'b0, 1'b1, 2'd1, 1'b1, 24'h000100);
            recv();
            send(24'hFFFF00, 1'b1, 1'b1, 2'd1, 1'b1, 24'hFFFF00);
            recv();
        end
    endtask

    // ---------------- main ----------------
    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        echo_en   = 1'b0;
        delay_sel = 2'd0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        m_ready   = 1'b1;
        model_clear();

        test_reset();
        test_echo_decay();
        test_bypass_random();
        test_sel_zero();
        test_saturation();
        test_backpressure();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
